// File: rtl/siphash_msg_fetch_if.sv
// siphash_msg_fetch_if: bus bundle between the message fetch stage, the
// message RAM and the SipHash core.
//   RAM side    : ram_address, ram_cs, ram_oe, ram_we (from fetch), ram_rdata (to fetch)
//   Stream side : m_valid, m_data, m_last (from fetch), m_ready (to fetch)
// master = fetch stage, slave = RAM + core side.
interface siphash_msg_fetch_if #(
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] ram_address;
  logic                  ram_cs;
  logic                  ram_oe;
  logic                  ram_we;
  logic [31:0]           ram_rdata;
  logic                  m_valid;
  logic                  m_ready;
  logic [63:0]           m_data;
  logic                  m_last;

  modport master (
    output ram_address, ram_cs, ram_oe, ram_we, m_valid, m_data, m_last,
    input  ram_rdata, m_ready
  );

  modport slave (
    input  ram_address, ram_cs, ram_oe, ram_we, m_valid, m_data, m_last,
    output ram_rdata, m_ready
  );
endinterface

// File: rtl/siphash_msg_fetch.sv
// siphash_msg_fetch: reads a byte-addressed message from a 32-bit RAM and
// packs it into 64-bit little-endian SipHash message words.
//   clk, rst_n          : clock, async active-low reset
//   start               : one-cycle request, sampled in IDLE only
//   base_addr, msg_len  : RAM word address of byte 0, length in bytes
//   busy, done          : busy while fetching, done pulses after final accept
//   bus (master)        : RAM read port and m_valid/m_ready word stream
// Build option: SIPHASH_FETCH_PAD_EN defined -> SipHash final block (tail
// bytes, zero fill, length byte). Undefined -> raw mode, msg_len/8 full
// blocks only, msg_len[2:0] ignored.
module siphash_msg_fetch #(
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  msg_len,
  output logic                  busy,
  output logic                  done,
  siphash_msg_fetch_if.master   bus
);

`ifdef SIPHASH_FETCH_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif

  // byte offset needs one extra bit so offset+7 never wraps
  localparam int OW = LEN_WIDTH + 1;

  typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, CAP_HI, OUT, DONE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;   // word address of word 2k
  logic [LEN_WIDTH-1:0]  len_q;
  logic [OW-1:0]         off_q;    // byte offset of block k (8k)
  logic [LEN_WIDTH-1:0]  blk_q;    // blocks still to emit, incl. current
  logic [31:0]           lo_q;
  logic [63:0]           data_q;
  logic                  last_q;

  logic [OW-1:0]         len_x;
  logic                  lo_en, hi_en, last_blk;
  logic [LEN_WIDTH-1:0]  nblk;
  logic [63:0]           asm_d;

  logic                  cs_c;
  logic [ADDR_WIDTH-1:0] addr_c;
  logic                  valid_c;

  assign len_x    = {1'b0, len_q};
  // a word is read only if its first byte lies inside the message
  assign lo_en    = off_q < len_x;
  assign hi_en    = (off_q + OW'(4)) < len_x;
  assign last_blk = (blk_q == LEN_WIDTH'(1));
  assign nblk     = (msg_len >> 3) + LEN_WIDTH'(PAD_EN);

  // Block assembly: high half straight from the RAM, bytes past the end
  // masked, then the length byte on the final padded block.
  always_comb begin
    asm_d = {(hi_en ? bus.ram_rdata : 32'h0), lo_q};
    for (int j = 0; j < 8; j++) begin
      if ((off_q + OW'(j)) >= len_x) asm_d[8*j +: 8] = 8'h00;
    end
    if (PAD_EN && last_blk) asm_d[63:56] = len_q[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    cs_c    = 1'b0;
    addr_c  = '0;
    valid_c = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: if (start) state_d = RD_LO;
      RD_LO: begin
        busy = 1'b1;
        // raw mode with msg_len < 8 has no blocks at all
        if (blk_q == '0) state_d = DONE;
        else begin
          cs_c    = lo_en;
          addr_c  = addr_q;
          state_d = RD_HI;
        end
      end
      RD_HI: begin
        busy    = 1'b1;
        cs_c    = hi_en;
        addr_c  = addr_q + ADDR_WIDTH'(1);
        state_d = CAP_HI;
      end
      CAP_HI: begin
        busy    = 1'b1;
        state_d = OUT;
      end
      OUT: begin
        busy    = 1'b1;
        valid_c = 1'b1;
        if (bus.m_ready) state_d = last_blk ? DONE : RD_LO;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      len_q  <= '0;
      off_q  <= '0;
      blk_q  <= '0;
      lo_q   <= '0;
      data_q <= '0;
      last_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          addr_q <= base_addr;
          len_q  <= msg_len;
          off_q  <= '0;
          blk_q  <= nblk;
        end
        RD_HI:  lo_q <= lo_en ? bus.ram_rdata : 32'h0;
        CAP_HI: begin
          data_q <= asm_d;
          last_q <= last_blk;
        end
        OUT: if (bus.m_ready && !last_blk) begin
          addr_q <= addr_q + ADDR_WIDTH'(2);
          off_q  <= off_q + OW'(8);
          blk_q  <= blk_q - LEN_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.ram_address = addr_c;
  assign bus.ram_cs      = cs_c;
  assign bus.ram_oe      = cs_c;
  assign bus.ram_we      = 1'b0;
  assign bus.m_valid     = valid_c;
  assign bus.m_data      = data_q;
  assign bus.m_last      = last_q;

endmodule
